// File: rtl/instr_fetch_stage_pkg.sv
// Shared constants and PC-select encoding for the MIPS IF stage.
// The HALT opcode lives here so the decode control unit decodes the same value.
package instr_fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [5:0]  HALT_OPCODE = 6'b111111;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_HALT   = 3'd1,
    SEL_STALL  = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_BRANCH = 3'd4,
    SEL_SEQ    = 3'd5
  } pc_sel_e;

  // Freeze beats halt beats stall beats jump beats branch beats sequential fetch.
  function automatic pc_sel_e select_pc(input logic enable, input logic halted,
                                        input logic halt, input logic stall,
                                        input logic jump, input logic branch);
    pc_sel_e sel;
    if (!enable || halted) begin
      sel = SEL_HOLD;
    end else if (halt) begin
      sel = SEL_HALT;
    end else if (stall) begin
      sel = SEL_STALL;
    end else if (jump) begin
      sel = SEL_JUMP;
    end else if (branch) begin
      sel = SEL_BRANCH;
    end else begin
      sel = SEL_SEQ;
    end
    return sel;
  endfunction

endpackage

// File: rtl/instr_fetch_stage_imem_bank.sv
// Instruction RAM: one synchronous write port for the debug loader and one
// asynchronous read port for fetch (a same-cycle write is seen on the next read).
module imem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Loader write port; contents are deliberately left untouched by reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: PC register, next-PC selection and the IF/ID pipeline register
// feeding decode, with stall, redirect flush, sticky halt and run-enable freeze.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_stall,
  input  logic                  i_branch,
  input  logic [DATA_WIDTH-1:0] i_pcbranch,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_pcjump,
  input  logic                  i_halt,
  input  logic                  i_load_en,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [DATA_WIDTH-1:0] o_currentpc,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_halted
);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] curpc_q, curpc_d;
  logic                  halted_q, halted_d;
  logic [DATA_WIDTH-1:0] fetch_word_s;
  logic [DATA_WIDTH-1:0] pc_plus4_s;
  pc_sel_e               sel_s;

  imem_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_imem (
    .clk_i   (i_clock),
    .we_i    (i_load_en),
    .waddr_i (i_load_addr),
    .wdata_i (i_load_data),
    .raddr_i (pc_q[ADDR_WIDTH+1:2]),
    .rdata_o (fetch_word_s)
  );

  assign pc_plus4_s = pc_q + DATA_WIDTH'(PC_STEP);
  assign sel_s      = select_pc(i_enable, halted_q, i_halt, i_stall, i_jump, i_branch);

  // Next-state for PC, IF/ID and halt flag; redirects flush the wrong-path fetch.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    curpc_d  = curpc_q;
    halted_d = halted_q;
    case (sel_s)
      SEL_HOLD, SEL_STALL: begin
      end
      SEL_HALT: begin
        halted_d = 1'b1;
        instr_d  = DATA_WIDTH'(NOP_INSTR);
      end
      SEL_JUMP: begin
        pc_d    = i_pcjump;
        instr_d = DATA_WIDTH'(NOP_INSTR);
      end
      SEL_BRANCH: begin
        pc_d    = i_pcbranch;
        instr_d = DATA_WIDTH'(NOP_INSTR);
      end
      SEL_SEQ: begin
        pc_d    = pc_plus4_s;
        instr_d = fetch_word_s;
        curpc_d = pc_plus4_s;
      end
      default: begin
      end
    endcase
  end

  // Stage state registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      pc_q     <= DATA_WIDTH'(RESET_PC);
      instr_q  <= DATA_WIDTH'(NOP_INSTR);
      curpc_q  <= {DATA_WIDTH{1'b0}};
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      curpc_q  <= curpc_d;
      halted_q <= halted_d;
    end
  end

  assign o_instruccion = instr_q;
  assign o_currentpc   = curpc_q;
  assign o_pc          = pc_q;
  assign o_halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed vector table, hand-written
// corner sequences and randomized traffic checked against a behavioural model.
module tb_instr_fetch_stage;

  localparam logic [31:0] W0  = 32'h2001_0005;
  localparam logic [31:0] W1  = 32'h2002_0007;
  localparam logic [31:0] W2  = 32'h0022_1820;
  localparam logic [31:0] W16 = 32'hAAAA_0010;
  localparam logic [31:0] W32 = 32'hBBBB_0020;

  logic        i_clock = 1'b0;
  logic        i_reset, i_enable, i_stall, i_branch, i_jump, i_halt, i_load_en;
  logic [31:0] i_pcbranch, i_pcjump, i_load_data;
  logic [7:0]  i_load_addr;
  logic [31:0] o_instruccion, o_currentpc, o_pc;
  logic        o_halted;

  instr_fetch_stage dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall),
    .i_branch(i_branch), .i_pcbranch(i_pcbranch), .i_jump(i_jump), .i_pcjump(i_pcjump),
    .i_halt(i_halt), .i_load_en(i_load_en), .i_load_addr(i_load_addr),
    .i_load_data(i_load_data), .o_instruccion(o_instruccion), .o_currentpc(o_currentpc),
    .o_pc(o_pc), .o_halted(o_halted)
  );

  always #5 i_clock = ~i_clock;

  // Behavioural reference state.
  logic [31:0] mem_m [256];
  logic [31:0] m_pc, m_instr, m_curpc;
  logic        m_halted, cur_known;
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct {
    logic en, stall, branch, jump, halt;
    logic [31:0] pcbranch, pcjump;
    logic [31:0] exp_pc, exp_instr, exp_cur;
    logic exp_halted;
  } vec_t;
  vec_t tbl [20];

  function automatic vec_t mk(logic en, logic stall, logic br, logic [31:0] pcb, logic jp,
                              logic [31:0] pcj, logic halt, logic [31:0] epc,
                              logic [31:0] einstr, logic [31:0] ecur, logic ehalt);
    vec_t v;
    v.en = en; v.stall = stall; v.branch = br; v.pcbranch = pcb; v.jump = jp;
    v.pcjump = pcj; v.halt = halt; v.exp_pc = epc; v.exp_instr = einstr;
    v.exp_cur = ecur; v.exp_halted = ehalt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_curpc = 32'h0; m_halted = 1'b0; cur_known = 1'b1;
  endtask

  // Next state straight from the prioritised rules; memory read precedes the loader write.
  task automatic model_update();
    logic [31:0] f;
    f = mem_m[int'((m_pc >> 2) % 32'd256)];
    if (i_enable && !m_halted) begin
      if (i_halt) begin
        m_halted = 1'b1; m_instr = 32'h0;
      end else if (i_stall) begin
      end else if (i_jump) begin
        m_pc = i_pcjump; m_instr = 32'h0; cur_known = 1'b0;
      end else if (i_branch) begin
        m_pc = i_pcbranch; m_instr = 32'h0; cur_known = 1'b0;
      end else begin
        m_instr = f; m_pc = m_pc + 32'd4; m_curpc = m_pc; cur_known = 1'b1;
      end
    end
    if (i_load_en) mem_m[i_load_addr] = i_load_data;
  endtask

  task automatic tick();
    model_update();
    @(posedge i_clock);
    #1;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_pc"}, o_pc, m_pc);
    chk({tag, "_instr"}, o_instruccion, m_instr);
    chk({tag, "_halted"}, {31'b0, o_halted}, {31'b0, m_halted});
    if (cur_known) chk({tag, "_curpc"}, o_currentpc, m_curpc);
  endtask

  task automatic idle_inputs();
    i_enable = 1'b1; i_stall = 1'b0; i_branch = 1'b0; i_jump = 1'b0; i_halt = 1'b0;
    i_load_en = 1'b0; i_pcbranch = 32'h0; i_pcjump = 32'h0;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear immediately.
  task automatic reset_pulse();
    #2 i_reset = 1'b0;
    #1;
    model_reset();
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_instr", o_instruccion, 32'h0);
    chk("rst_curpc", o_currentpc, 32'h0);
    chk("rst_halted", {31'b0, o_halted}, 32'h0);
    #2 i_reset = 1'b1;
  endtask

  initial begin
    i_reset = 1'b0; idle_inputs(); i_enable = 1'b0;
    i_load_addr = 8'h0; i_load_data = 32'h0;
    model_reset();
    #3;
    chk("reset_pc", o_pc, 32'h0);
    chk("reset_instr", o_instruccion, 32'h0);
    chk("reset_curpc", o_currentpc, 32'h0);
    chk("reset_halted", {31'b0, o_halted}, 32'h0);
    @(posedge i_clock); #1;
    chk("reset_hold_pc", o_pc, 32'h0);
    i_reset = 1'b1;

    // Fill the whole memory with enable low; the stage must not move.
    for (int a = 0; a < 256; a++) begin
      i_load_en = 1'b1; i_load_addr = 8'(a);
      case (a)
        0:       i_load_data = W0;
        1:       i_load_data = W1;
        2:       i_load_data = W2;
        16:      i_load_data = W16;
        32:      i_load_data = W32;
        default: i_load_data = $urandom;
      endcase
      tick();
    end
    i_load_en = 1'b0;
    chk("load_pc_frozen", o_pc, 32'h0);
    chk("load_instr_frozen", o_instruccion, 32'h0);

    tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 32'h4, W0, 32'h4, 0);
    tbl[1] = mk(1, 0, 0, 0, 0, 0, 0, 32'h8, W1, 32'h8, 0);
    tbl[2] = mk(1, 0, 1, 32'h40, 0, 0, 0, 32'h40, 32'h0, 32'h8, 0);
    tbl[3] = mk(1, 0, 0, 0, 0, 0, 0, 32'h44, W16, 32'h44, 0);
    tbl[4] = mk(1, 0, 1, 32'h40, 1, 32'h80, 0, 32'h80, 32'h0, 32'h44, 0);
    tbl[5] = mk(1, 1, 0, 0, 1, 32'h8, 0, 32'h80, 32'h0, 32'h44, 0);
    tbl[6] = mk(1, 0, 0, 0, 0, 0, 0, 32'h84, W32, 32'h84, 0);
    tbl[7] = mk(1, 0, 0, 0, 1, 32'h8, 0, 32'h8, 32'h0, 32'h84, 0);
    tbl[8] = mk(1, 0, 0, 0, 0, 0, 0, 32'hC, W2, 32'hC, 0);
    tbl[9] = mk(1, 0, 0, 0, 0, 0, 1, 32'hC, 32'h0, 32'hC, 1);
    for (int i = 10; i < 20; i++)
      tbl[i] = mk(1, 0, 1, 32'h40, 1, 32'h100, 0, 32'hC, 32'h0, 32'hC, 1);

    for (int i = 0; i < 20; i++) begin
      i_enable = tbl[i].en; i_stall = tbl[i].stall; i_branch = tbl[i].branch;
      i_pcbranch = tbl[i].pcbranch; i_jump = tbl[i].jump; i_pcjump = tbl[i].pcjump;
      i_halt = tbl[i].halt;
      tick();
      chk($sformatf("vec%0d_pc", i), o_pc, tbl[i].exp_pc);
      chk($sformatf("vec%0d_instr", i), o_instruccion, tbl[i].exp_instr);
      chk($sformatf("vec%0d_curpc", i), o_currentpc, tbl[i].exp_cur);
      chk($sformatf("vec%0d_halted", i), {31'b0, o_halted}, {31'b0, tbl[i].exp_halted});
    end
    idle_inputs();

    reset_pulse();

    // Run, then freeze with a loader write to the word being fetched.
    for (int i = 0; i < 3; i++) begin tick(); compare_model("run"); end
    i_enable = 1'b0;
    tick(); compare_model("frz0");
    i_load_en = 1'b1; i_load_addr = o_pc[9:2]; i_load_data = 32'hCAFE_0003;
    tick(); compare_model("frz1");
    i_load_en = 1'b0;
    tick(); compare_model("frz2");
    i_enable = 1'b1;
    tick(); compare_model("refetch");
    chk("refetch_new_word", o_instruccion, 32'hCAFE_0003);

    // Same-cycle write to the fetched word: old word now, new word on re-fetch.
    i_load_en = 1'b1; i_load_addr = o_pc[9:2]; i_load_data = 32'hD00D_0004;
    i_pcjump = o_pc;
    tick(); compare_model("rbw_old");
    i_load_en = 1'b0; i_jump = 1'b1;
    tick(); compare_model("rbw_jump");
    i_jump = 1'b0;
    tick(); compare_model("rbw_new");
    chk("rbw_new_word", o_instruccion, 32'hD00D_0004);

    // Address wrap at the top of memory and PC wrap at 2^32.
    i_jump = 1'b1; i_pcjump = 32'h3F8;
    tick(); compare_model("wrap_j");
    i_jump = 1'b0;
    tick(); compare_model("wrap_254");
    tick(); compare_model("wrap_255");
    chk("wrap_curpc_400", o_currentpc, 32'h400);
    tick(); compare_model("wrap_0");
    chk("wrap_word0", o_instruccion, W0);
    i_jump = 1'b1; i_pcjump = 32'hFFFF_FFFC;
    tick(); compare_model("pcwrap_j");
    i_jump = 1'b0;
    tick(); compare_model("pcwrap");
    chk("pcwrap_pc_zero", o_pc, 32'h0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      i_enable    = ($urandom % 8) != 0;
      i_stall     = ($urandom % 5) == 0;
      i_jump      = ($urandom % 8) == 0;
      i_branch    = ($urandom % 6) == 0;
      i_halt      = ($urandom % 60) == 0;
      i_pcjump    = $urandom % 32'd2048;
      i_pcbranch  = $urandom;
      i_load_en   = ($urandom % 4) == 0;
      i_load_addr = 8'($urandom);
      i_load_data = $urandom;
      tick();
      compare_model("rand");
      if (m_halted && ($urandom % 6) == 0) reset_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
